// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared types and constants for the instruction fetch front end.
// Revision: 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned INSN_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Brief   : Synchronous FIFO of fetched {pc, insn} entries with clear.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  fetch_entry_t               i_push_data,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output fetch_entry_t               o_head
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 w_do_pop;
    logic                 w_do_push;

    function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
        return (p == c_last) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != c_cnt_w'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch
// Brief   : Fetch PC, credit-limited imem requests, response queue, redirect
//           squash. Optional misaligned-redirect fault: FETCH_MISALIGN_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        dec_en,
    output logic [31:0] instruction_code,
    output logic [31:0] instruction_pc,
    output logic        fetch_fault
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_rsp_pc;
    logic [c_cnt_w-1:0] r_outstanding;
    logic [c_cnt_w-1:0] r_discard;
    logic [c_cnt_w-1:0] w_outstanding_next;
    logic [c_cnt_w-1:0] w_discard_next;
    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w:0]   w_inflight;
    logic               w_empty;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_data;
    logic               w_fault;
    logic               w_credit_ok;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_push;
    logic               w_pop;
    logic               w_dec_en;
    logic [31:0]        w_redirect_target;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_fault;

    always_ff @(posedge clk) begin
        if (rst)                 r_fault <= 1'b0;
        else if (redirect_valid) r_fault <= |redirect_pc[1:0];
    end

    assign w_fault           = r_fault;
    assign w_redirect_target = redirect_pc;
`else
    assign w_fault           = 1'b0;
    assign w_redirect_target = redirect_pc & ~32'h0000_0003;
`endif

    // Queue entries plus in-flight requests must never exceed the queue size.
    assign w_inflight  = {1'b0, w_count} + {1'b0, r_outstanding};
    assign w_credit_ok = w_inflight < (c_cnt_w + 1)'(FIFO_DEPTH);

    assign w_req_valid = !rst && (r_state == RUN) && !redirect_valid && w_credit_ok && !w_fault;
    assign w_req_fire  = w_req_valid && imem_req_ready;
    assign w_push      = imem_rsp_valid && (r_discard == '0) && !redirect_valid;
    assign w_dec_en    = !rst && !w_empty;
    assign w_pop       = w_dec_en && dec_ready;
    assign w_push_data = '{pc: r_rsp_pc, insn: imem_rsp_data};

    assign w_outstanding_next = r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(imem_rsp_valid);

    always_comb begin
        w_state_next   = r_state;
        w_discard_next = r_discard;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old stream.
            w_discard_next = w_outstanding_next;
            w_state_next   = (w_outstanding_next != '0) ? DRAIN : RUN;
        end else begin
            if (imem_rsp_valid && (r_discard != '0)) w_discard_next = r_discard - 1'b1;
            if ((r_state == DRAIN) && (w_discard_next == '0)) w_state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            r_discard     <= w_discard_next;
            if (redirect_valid)  r_fetch_pc <= w_redirect_target;
            else if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'(INSN_BYTES);
            // Responses return in order, so the next kept one is always at r_rsp_pc.
            if (redirect_valid)  r_rsp_pc <= w_redirect_target;
            else if (w_push)     r_rsp_pc <= r_rsp_pc + 32'(INSN_BYTES);
        end
    end

    fetch_queue #(
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_clear     (redirect_valid),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

    assign imem_req_valid   = w_req_valid;
    assign imem_req_addr    = w_req_valid ? r_fetch_pc : 32'h0;
    assign dec_en           = w_dec_en;
    assign instruction_code = w_dec_en ? w_head.insn : 32'h0;
    assign instruction_pc   = w_dec_en ? w_head.pc : 32'h0;
    assign fetch_fault      = !rst && w_fault;

endmodule
`default_nettype wire
